// File: rtl/dom_masked_pkg.sv
// dom_masked_pkg: shared share count and width/offset helpers for the DOM masked AND chain
package dom_masked_pkg;
    localparam int NUM_SHARES = 2;
    function automatic int rnd_width(input int n_in, input int width, input bit refresh);
        return width * (refresh ? n_in : n_in - 1);
    endfunction
    function automatic int op_off(input int k, input int width);
        return k * width;
    endfunction
endpackage

// File: rtl/dom_and2_reg.sv
// dom_and2_reg: one registered two-share DOM-indep AND gadget over WIDTH independent lanes
module dom_and2_reg
    import dom_masked_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_en,
    input  logic [NUM_SHARES-1:0][WIDTH-1:0] i_a,
    input  logic [NUM_SHARES-1:0][WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0]                 i_r,
    output logic [NUM_SHARES-1:0][WIDTH-1:0] o_y
);
    logic [WIDTH-1:0] r_i0, r_i1, r_c01, r_c10;
    // Register inner products and remasked cross products so nothing recombines before a register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_i0  <= '0;
            r_i1  <= '0;
            r_c01 <= '0;
            r_c10 <= '0;
        end else if (i_en) begin
            r_i0  <= i_a[0] & i_b[0];
            r_i1  <= i_a[1] & i_b[1];
            r_c01 <= (i_a[0] & i_b[1]) ^ i_r;
            r_c10 <= (i_a[1] & i_b[0]) ^ i_r;
        end
    end
    assign o_y = {r_i1 ^ r_c10, r_i0 ^ r_c01};
endmodule

// File: rtl/dom_and_chain_masked.sv
// dom_and_chain_masked: pipelined two-share masked AND of N_IN operands with valid/ready handshake
// Define DOM_OUT_REFRESH_EN to append a registered remasking stage after the last gadget.
module dom_and_chain_masked
    import dom_masked_pkg::*;
#(
    parameter int N_IN  = 3,
    parameter int WIDTH = 1,
`ifdef DOM_OUT_REFRESH_EN
    localparam bit REFRESH = 1'b1,
`else
    localparam bit REFRESH = 1'b0,
`endif
    localparam int RND_W = rnd_width(N_IN, WIDTH, REFRESH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N_IN*WIDTH-1:0] x0,
    input  logic [N_IN*WIDTH-1:0] x1,
    input  logic [RND_W-1:0]      rnd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      y0,
    output logic [WIDTH-1:0]      y1
);
    localparam int NG  = N_IN - 1;
    localparam int NST = NG + int'(REFRESH);

    logic                             w_en;
    logic [NST-1:0]                   r_v;
    logic [NUM_SHARES-1:0][WIDTH-1:0] w_o [NG];

    assign w_en      = !out_valid || out_ready;
    assign in_ready  = w_en;
    assign out_valid = r_v[NST-1];

    // Valid bits march with the data; bubbles are kept, never squeezed out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_v <= '0;
        else if (w_en) r_v <= (r_v << 1) | NST'(in_valid);
    end

    for (genvar s = 0; s < N_IN - 2; s++) begin : g_od
        localparam int OW = (N_IN - 2 - s) * WIDTH;
        logic [NUM_SHARES-1:0][OW-1:0] r_d;
        logic [NUM_SHARES-1:0][OW-1:0] w_d;
        if (s == 0) begin : g_src
            assign w_d = {x1[N_IN*WIDTH-1:op_off(2, WIDTH)], x0[N_IN*WIDTH-1:op_off(2, WIDTH)]};
        end else begin : g_src
            assign w_d = {g_od[s-1].r_d[1][OW+WIDTH-1:WIDTH], g_od[s-1].r_d[0][OW+WIDTH-1:WIDTH]};
        end
        // Carry not-yet-consumed operands share-wise so each meets its gadget in the same beat
        always_ff @(posedge clk or posedge rst) begin
            if (rst) r_d <= '0;
            else if (w_en) r_d <= w_d;
        end
    end

    for (genvar s = 0; s < NST - 1; s++) begin : g_rd
        localparam int RW = (NST - 1 - s) * WIDTH;
        logic [RW-1:0] r_r;
        logic [RW-1:0] w_r;
        if (s == 0) begin : g_src
            assign w_r = rnd[RND_W-1:WIDTH];
        end else begin : g_src
            assign w_r = g_rd[s-1].r_r[RW+WIDTH-1:WIDTH];
        end
        // Randomness drawn at accept travels with its beat until its consumer stage
        always_ff @(posedge clk or posedge rst) begin
            if (rst) r_r <= '0;
            else if (w_en) r_r <= w_r;
        end
    end

    for (genvar g = 0; g < NG; g++) begin : g_gad
        logic [NUM_SHARES-1:0][WIDTH-1:0] w_a, w_b;
        logic [WIDTH-1:0]                 w_r;
        if (g == 0) begin : g_in
            assign w_a = {x1[op_off(0, WIDTH) +: WIDTH], x0[op_off(0, WIDTH) +: WIDTH]};
            assign w_b = {x1[op_off(1, WIDTH) +: WIDTH], x0[op_off(1, WIDTH) +: WIDTH]};
            assign w_r = rnd[WIDTH-1:0];
        end else begin : g_in
            assign w_a = w_o[g-1];
            assign w_b = {g_od[g-1].r_d[1][WIDTH-1:0], g_od[g-1].r_d[0][WIDTH-1:0]};
            assign w_r = g_rd[g-1].r_r[WIDTH-1:0];
        end
        dom_and2_reg #(.WIDTH(WIDTH)) u_gad (
            .clk  (clk),
            .rst  (rst),
            .i_en (w_en),
            .i_a  (w_a),
            .i_b  (w_b),
            .i_r  (w_r),
            .o_y  (w_o[g])
        );
    end

`ifdef DOM_OUT_REFRESH_EN
    logic [WIDTH-1:0] r_y0, r_y1;
    // Remask the final shares with the last fresh slice before they leave the block
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y0 <= '0;
            r_y1 <= '0;
        end else if (w_en) begin
            r_y0 <= w_o[NG-1][0] ^ g_rd[NST-2].r_r;
            r_y1 <= w_o[NG-1][1] ^ g_rd[NST-2].r_r;
        end
    end
    assign y0 = r_y0;
    assign y1 = r_y1;
`else
    assign y0 = w_o[NG-1][0];
    assign y1 = w_o[NG-1][1];
`endif
endmodule

// File: tb/tb_dom_and_chain_masked.sv
// tb_dom_and_chain_masked: randomized scenario bench for the masked AND chain (N_IN=3 x1 and N_IN=4 x8)
module tb_dom_and_chain_masked;
`ifdef DOM_OUT_REFRESH_EN
    localparam int REF = 1;
`else
    localparam int REF = 0;
`endif
    localparam int L3  = 2 + REF;
    localparam int L4  = 3 + REF;
    localparam int RW3 = 2 + REF;
    localparam int RW4 = 8 * (3 + REF);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic v3 = 1'b0, or3 = 1'b1, rdy3, ov3, y30, y31;
    logic [2:0] a0 = '0, a1 = '0;
    logic [RW3-1:0] r3 = '0;
    logic v4 = 1'b0, or4 = 1'b1, rdy4, ov4;
    logic [31:0] b0 = '0, b1 = '0;
    logic [RW4-1:0] r4 = '0;
    logic [7:0] y40, y41;
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dom_and_chain_masked #(.N_IN(3), .WIDTH(1)) dut3 (
        .clk(clk), .rst(rst), .in_valid(v3), .in_ready(rdy3), .x0(a0), .x1(a1), .rnd(r3),
        .out_valid(ov3), .out_ready(or3), .y0(y30), .y1(y31)
    );

    dom_and_chain_masked #(.N_IN(4), .WIDTH(8)) dut4 (
        .clk(clk), .rst(rst), .in_valid(v4), .in_ready(rdy4), .x0(b0), .x1(b1), .rnd(r4),
        .out_valid(ov4), .out_ready(or4), .y0(y40), .y1(y41)
    );

    // Unmasked reference: bitwise AND of the four recombined byte operands
    function automatic logic [7:0] ref_and4(input logic [31:0] u);
        logic [7:0] acc;
        acc = 8'hFF;
        for (int k = 0; k < 4; k++) acc &= u[k*8 +: 8];
        return acc;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        #3;
        n_chk++; if (ov3 !== 1'b0) begin n_fail++; $display("FAIL reset_ov3 got %0b want 0", ov3); end
        n_chk++; if ({y30, y31} !== 2'b00) begin n_fail++; $display("FAIL reset_y3 got %b want 00", {y30, y31}); end
        n_chk++; if ({ov4, y40, y41} !== 17'h0) begin n_fail++; $display("FAIL reset_dut4 got %h want 0", {ov4, y40, y41}); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_chk++; if (rdy3 !== 1'b1) begin n_fail++; $display("FAIL reset_rdy3 got %0b want 1", rdy3); end
        n_chk++; if (rdy4 !== 1'b1) begin n_fail++; $display("FAIL reset_rdy4 got %0b want 1", rdy4); end
    endtask

    task automatic test_exhaustive();
        logic q_e[$];
        int q_t[$];
        logic [2:0] m;
        logic e;
        int t, got;
        got = 0;
        or3 = 1'b1;
        for (int c = 0; c < 32 + L3 + 2; c++) begin
            @(negedge clk);
            m = 3'($urandom);
            a0 = m;
            a1 = m ^ 3'(c % 8);
            r3 = RW3'($urandom);
            v3 = (c < 32);
            #1;
            if (ov3 && or3) begin
                got++;
                if (q_e.size() == 0) begin
                    n_chk++; n_fail++; $display("FAIL exh_extra beat at cycle %0d with nothing pending", c);
                end else begin
                    e = q_e.pop_front();
                    t = q_t.pop_front();
                    n_chk++; if ((y30 ^ y31) !== e) begin n_fail++; $display("FAIL exh_value cycle %0d got %0b want %0b", c, y30 ^ y31, e); end
                    n_chk++; if (c - t !== L3) begin n_fail++; $display("FAIL exh_latency got %0d want %0d", c - t, L3); end
                end
            end
            if (v3 && rdy3) begin
                q_e.push_back(&(a0 ^ a1));
                q_t.push_back(c);
            end
        end
        n_chk++; if (got !== 32) begin n_fail++; $display("FAIL exh_count got %0d want 32", got); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] q_e[$];
        int q_t[$], q_i[$];
        logic [31:0] u;
        logic [7:0] e;
        int t, i, got, last, nxt;
        got = 0; last = -1; nxt = 0;
        or4 = 1'b1;
        for (int c = 0; c < 20 + L4 + 3; c++) begin
            @(negedge clk);
            u = (nxt == 5) ? 32'hAA3CF0FF : $urandom;
            b0 = $urandom;
            b1 = b0 ^ u;
            r4 = RW4'($urandom);
            v4 = (nxt < 20);
            #1;
            if (ov4 && or4) begin
                got++;
                if (q_e.size() == 0) begin
                    n_chk++; n_fail++; $display("FAIL b2b_extra beat at cycle %0d", c);
                end else begin
                    e = q_e.pop_front(); t = q_t.pop_front(); i = q_i.pop_front();
                    n_chk++; if ((y40 ^ y41) !== e) begin n_fail++; $display("FAIL b2b_value beat %0d got %h want %h", i, y40 ^ y41, e); end
                    n_chk++; if (c - t !== L4) begin n_fail++; $display("FAIL b2b_latency beat %0d got %0d want %0d", i, c - t, L4); end
                    if (i == 5) begin
                        n_chk++; if ((y40 ^ y41) !== 8'h20) begin n_fail++; $display("FAIL b2b_known got %h want 20", y40 ^ y41); end
                    end
                    if (last >= 0) begin
                        n_chk++; if (c - last !== 1) begin n_fail++; $display("FAIL b2b_rate gap %0d want 1", c - last); end
                    end
                    last = c;
                end
            end
            if (v4 && rdy4) begin
                q_e.push_back(ref_and4(b0 ^ b1));
                q_t.push_back(c);
                q_i.push_back(nxt);
                nxt++;
            end
        end
        n_chk++; if (got !== 20) begin n_fail++; $display("FAIL b2b_count got %0d want 20", got); end
    endtask

    task automatic test_backpressure();
        logic q_e[$];
        logic [2:0] c0, c1, prev;
        int got, nxt;
        got = 0; nxt = 0; prev = '0;
        c0 = 3'($urandom); c1 = 3'($urandom);
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            or3 = !(c >= 6 && c < 11);
            a0 = c0; a1 = c1;
            r3 = RW3'($urandom);
            v3 = (nxt < 15);
            #1;
            if (!or3) begin
                n_chk++; if (rdy3 !== 1'b0) begin n_fail++; $display("FAIL bp_ready cycle %0d got %0b want 0", c, rdy3); end
            end
            if (c >= 7 && c < 11) begin
                n_chk++; if ({ov3, y30, y31} !== prev) begin n_fail++; $display("FAIL bp_hold cycle %0d got %b want %b", c, {ov3, y30, y31}, prev); end
            end
            prev = {ov3, y30, y31};
            if (ov3 && or3) begin
                got++;
                if (q_e.size() == 0) begin
                    n_chk++; n_fail++; $display("FAIL bp_dup extra beat at cycle %0d", c);
                end else begin
                    n_chk++; if ((y30 ^ y31) !== q_e[0]) begin n_fail++; $display("FAIL bp_value cycle %0d got %0b want %0b", c, y30 ^ y31, q_e[0]); end
                    void'(q_e.pop_front());
                end
            end
            if (v3 && rdy3) begin
                q_e.push_back(&(c0 ^ c1));
                nxt++;
                c0 = 3'($urandom); c1 = 3'($urandom);
            end
        end
        n_chk++; if (got !== 15) begin n_fail++; $display("FAIL bp_count got %0d want 15", got); end
        or3 = 1'b1;
    endtask

    task automatic test_rnd_dependence();
        logic [2:0] f0, f1;
        logic ya0, ya1, yb0, yb1, va, vb;
        f1 = 3'b100;
        f0 = REF ? 3'b001 : 3'b101;
        ya0 = 0; ya1 = 0; yb0 = 0; yb1 = 0; va = 0; vb = 0;
        or3 = 1'b1;
        for (int c = 0; c < L3 + 2; c++) begin
            @(negedge clk);
            v3 = (c < 2);
            a0 = f0; a1 = f1;
            r3 = (c == 0) ? '0 : '1;
            #1;
            if (c == L3) begin ya0 = y30; ya1 = y31; va = ov3; end
            if (c == L3 + 1) begin yb0 = y30; yb1 = y31; vb = ov3; end
        end
        n_chk++; if ({va, vb} !== 2'b11) begin n_fail++; $display("FAIL rnd_valid got %b want 11", {va, vb}); end
        n_chk++; if ((ya0 ^ ya1) !== &(f0 ^ f1)) begin n_fail++; $display("FAIL rnd_value0 got %0b want %0b", ya0 ^ ya1, &(f0 ^ f1)); end
        n_chk++; if ((yb0 ^ yb1) !== &(f0 ^ f1)) begin n_fail++; $display("FAIL rnd_value1 got %0b want %0b", yb0 ^ yb1, &(f0 ^ f1)); end
        n_chk++; if (yb0 === ya0) begin n_fail++; $display("FAIL rnd_y0_change got %0b then %0b want different", ya0, yb0); end
        for (int c = 0; c < L3 + 1; c++) begin
            @(negedge clk);
            v3 = (c == 0);
            a0 = 3'b111; a1 = 3'b000; r3 = '0;
            #1;
            if (c == L3) begin
                n_chk++; if ({ov3, y30, y31} !== 3'b110) begin n_fail++; $display("FAIL rnd_zero got v,y0,y1=%b want 110", {ov3, y30, y31}); end
            end
        end
        v3 = 1'b0;
    endtask

    task automatic test_async_reset();
        or3 = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            v3 = 1'b1; a0 = 3'b111; a1 = 3'b000; r3 = '0;
        end
        #1;
        n_chk++; if ({ov3, y30} !== 2'b11) begin n_fail++; $display("FAIL arst_pre got %b want 11", {ov3, y30}); end
        #1;
        rst = 1'b1;
        #1;
        n_chk++; if (clk !== 1'b0) begin n_fail++; $display("FAIL arst_phase clk %0b want 0", clk); end
        n_chk++; if ({ov3, y30, y31} !== 3'b000) begin n_fail++; $display("FAIL arst_clear got %b want 000", {ov3, y30, y31}); end
        v3 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < L3 + 4; c++) begin
            @(negedge clk);
            #1;
            n_chk++; if (ov3 !== 1'b0) begin n_fail++; $display("FAIL arst_ghost cycle %0d out_valid %0b want 0", c, ov3); end
        end
        n_chk++; if (rdy3 !== 1'b1) begin n_fail++; $display("FAIL arst_ready got %0b want 1", rdy3); end
    endtask

`ifdef DOM_OUT_REFRESH_EN
    task automatic test_refresh();
        or3 = 1'b1;
        for (int c = 0; c < L3 + 1; c++) begin
            @(negedge clk);
            v3 = (c == 0);
            a0 = 3'b111; a1 = 3'b000; r3 = 3'b100;
            #1;
            if (c == L3 - 1) begin
                n_chk++; if (ov3 !== 1'b0) begin n_fail++; $display("FAIL ref_early out_valid %0b want 0", ov3); end
            end
            if (c == L3) begin
                n_chk++; if ({ov3, y30, y31} !== 3'b101) begin n_fail++; $display("FAIL ref_shares got v,y0,y1=%b want 101", {ov3, y30, y31}); end
            end
        end
        v3 = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_exhaustive();
        test_back_to_back();
        test_backpressure();
        test_rnd_dependence();
`ifdef DOM_OUT_REFRESH_EN
        test_refresh();
`endif
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
